// File: rtl/credit_tx_pkg.sv
// credit_tx_pkg: shared types and widths for the credit-based transmit link.
//   DATA_WIDTH   - payload width of a fabric word (predicate bit is added on top)
//   CREDIT_WIDTH - default credit counter width
//   WORD_W       - full word width on the link (payload + predicate)
//   tx_state_e   - transmit FSM encodings
//   next_state() - FSM state implied by next-cycle occupancy and credit status
package credit_tx_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int CREDIT_WIDTH = 3;
    localparam int WORD_W       = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACTIVE  = 2'b01,
        ST_STALL   = 2'b10,
        ST_ILLEGAL = 2'b11
    } tx_state_e;

    // The FSM is fully determined by whether the buffer holds words and
    // whether any credit remains after the current edge.
    function automatic tx_state_e next_state(input logic nonempty, input logic has_credit);
        if (!nonempty) begin
            return ST_IDLE;
        end else if (has_credit) begin
            return ST_ACTIVE;
        end else begin
            return ST_STALL;
        end
    endfunction

endpackage

// File: rtl/credit_tx_credit_cnt.sv
// credit_cnt: saturating up/down credit counter for the transmit link.
//   clk, rst_n  - clock, asynchronous active-low reset (loads INIT)
//   inc         - credit returned by downstream this cycle
//   dec         - word transmitted this cycle (caller guarantees count > 0)
//   count       - registered credit count
//   count_next  - value count takes at the next edge
//   ovf         - sticky: a credit arrived while already full with no pop
module credit_cnt #(
    parameter int INIT  = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT);

    logic ovf_now;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        ovf_now    = 1'b0;
        if (inc && !dec) begin
            if (count == INIT_C) begin
                ovf_now = 1'b1;          // extra credit: hold at full, flag it
            end else begin
                count_next = count + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count_next = count - CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= INIT_C;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            if (ovf_now) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_tx.sv
// credit_tx: transmit end of a credit-based flow-control link.
// Buffers up to two core words and forwards them as single-cycle valid
// pulses while downstream credits remain.
//   clk, rst_n - clock, asynchronous active-low reset
//   d_in       - word from core (payload + predicate bit)
//   send       - core strobe; counts only when accept=1
//   accept     - buffer has room this cycle (registered state only)
//   credit_in  - one-cycle pulse from downstream returning one slot
//   d_out      - registered word to fabric
//   v_out      - registered; one pulse per transmitted word
//   credits    - current credit count
//   stall      - buffer non-empty and no credits
//   err        - sticky credit overflow
module credit_tx
    import credit_tx_pkg::*;
#(
    parameter int ID      = 0,
    parameter int CREDITS = 4,
    parameter int CNT_W   = CREDIT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] d_in,
    input  logic              send,
    output logic              accept,
    input  logic              credit_in,
    output logic [WORD_W-1:0] d_out,
    output logic              v_out,
    output logic [CNT_W-1:0]  credits,
    output logic              stall,
    output logic              err
);

    // A misconfigured instance loads zero credits and never transmits, so it
    // shows up immediately instead of silently overrunning downstream.
    localparam bit PARAMS_OK = (CREDITS >= 1) && (CREDITS <= 7) &&
                               (CREDITS < (1 << CNT_W)) && (ID >= 0);
    localparam int INIT_CREDITS = PARAMS_OK ? CREDITS : 0;

    logic [WORD_W-1:0] buf_mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        occ;
    logic [1:0]        occ_next;
    tx_state_e         state;
    tx_state_e         state_next;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  credits_next;

    assign accept = (occ < 2'd2);
    assign push   = send & accept;
    // Pop needs a credit, which is what keeps the counter from underflowing.
    assign pop    = (occ != 2'd0) & (credits != '0);
    assign stall  = (state == ST_STALL);

    credit_cnt #(
        .INIT  (INIT_CREDITS),
        .CNT_W (CNT_W)
    ) u_credit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (credit_in),
        .dec        (pop),
        .count      (credits),
        .count_next (credits_next),
        .ovf        (err)
    );

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 2'd1;
        end else if (pop && !push) begin
            occ_next = occ - 2'd1;
        end
        state_next = (state == ST_ILLEGAL) ? ST_IDLE
                   : next_state(occ_next != 2'd0, credits_next != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
            state  <= ST_IDLE;
            v_out  <= 1'b0;
            d_out  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                d_out  <= buf_mem[rd_ptr];
            end
            occ   <= occ_next;
            state <= state_next;
            v_out <= pop;
        end
    end

    // NOTE: buffer storage is deliberately not reset; occupancy and pointers
    // define validity, and leaving the array reset-free lets it map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= d_in;
        end
    end

endmodule

// File: tb/tb_credit_tx.sv
// tb_credit_tx: scoreboard bench for credit_tx. Stimulus pushes accepted
// words into an expected queue; a negedge monitor pops and compares on v_out.
module tb_credit_tx;
    import credit_tx_pkg::*;

    localparam int W       = WORD_W;
    localparam int CREDITS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] d_in = '0;
    logic         send = 1'b0;
    logic         accept;
    logic         credit_in = 1'b0;
    logic [W-1:0] d_out;
    logic         v_out;
    logic [2:0]   credits;
    logic         stall;
    logic         err;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q [$];

    credit_tx #(
        .ID      (0),
        .CREDITS (CREDITS),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (d_in),
        .send      (send),
        .accept    (accept),
        .credit_in (credit_in),
        .d_out     (d_out),
        .v_out     (v_out),
        .credits   (credits),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle from a negedge; an accepted word is pushed to the
    // scoreboard before the edge that writes it.
    task automatic cycle(input logic s, input logic [W-1:0] d, input logic c, output logic took);
        send      = s;
        d_in      = d;
        credit_in = c;
        took      = s && accept;
        if (took) exp_q.push_back(d);
        @(negedge clk);
        send      = 1'b0;
        credit_in = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest outstanding word.
    always @(negedge clk) begin
        if (rst_n && v_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", d_out);
            end else begin
                check("fifo_order", 32'(d_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic         tk;
        logic         s;
        logic         cr;
        logic [W-1:0] word;
        int           ds;
        int           accepted;
        int           cyc;

        // 1: reset values
        repeat (2) @(negedge clk);
        check("rst_accept",  accept,  1);
        check("rst_credits", credits, 4);
        check("rst_v_out",   v_out,   0);
        check("rst_stall",   stall,   0);
        check("rst_err",     err,     0);
        rst_n = 1'b1;

        // 2: four words back to back, no credit return
        cycle(1'b1, 17'h0_00A1, 1'b0, tk);
        check("t2_latency_v", v_out, 0);
        check("t2_cred_a", credits, 4);
        cycle(1'b1, 17'h1_00B2, 1'b0, tk);
        check("t2_v_a", v_out, 1);
        check("t2_cred_b", credits, 3);
        cycle(1'b1, 17'h0_00C3, 1'b0, tk);
        check("t2_cred_c", credits, 2);
        cycle(1'b1, 17'h1_00D4, 1'b0, tk);
        check("t2_cred_d", credits, 1);
        cycle(1'b0, '0, 1'b0, tk);
        check("t2_cred_empty", credits, 0);
        check("t2_v_d", v_out, 1);
        check("t2_idle_stall", stall, 0);

        // 3: E and F fill the buffer with no credits
        cycle(1'b1, 17'h0_00E5, 1'b0, tk);
        check("t3_stall_e", stall, 1);
        check("t3_v_e", v_out, 0);
        cycle(1'b1, 17'h1_00F6, 1'b0, tk);
        check("t3_accept_full", accept, 0);
        check("t3_stall_f", stall, 1);
        cycle(1'b1, 17'h0_0077, 1'b0, tk);   // refused: accept was 0
        check("t3_refused", tk, 0);
        check("t3_accept_still", accept, 0);
        cycle(1'b0, '0, 1'b1, tk);
        check("t3_cred_ret", credits, 1);
        check("t3_v_wait", v_out, 0);
        check("t3_active", stall, 0);
        cycle(1'b0, '0, 1'b0, tk);
        check("t3_v_e_out", v_out, 1);
        check("t3_d_e_out", d_out, 17'h0_00E5);
        check("t3_cred_zero", credits, 0);
        check("t3_f_held_stall", stall, 1);
        check("t3_accept_back", accept, 1);

        // 4: transmit and credit return at the same edge at credits=2
        cycle(1'b0, '0, 1'b1, tk);
        check("t4_cred1", credits, 1);
        cycle(1'b0, '0, 1'b0, tk);
        check("t4_d_f", d_out, 17'h1_00F6);
        cycle(1'b0, '0, 1'b1, tk);
        cycle(1'b0, '0, 1'b1, tk);
        check("t4_cred2", credits, 2);
        cycle(1'b1, 17'h1_0058, 1'b0, tk);
        check("t4_no_bypass", v_out, 0);
        cycle(1'b0, '0, 1'b1, tk);
        check("t4_cred_same", credits, 2);
        check("t4_v", v_out, 1);
        check("t4_d", d_out, 17'h1_0058);
        check("t4_idle", stall, 0);

        // 5: overflow credit, then reset in STALL
        cycle(1'b0, '0, 1'b1, tk);
        cycle(1'b0, '0, 1'b1, tk);
        check("t5_cred_full", credits, 4);
        check("t5_no_err_yet", err, 0);
        cycle(1'b0, '0, 1'b1, tk);
        check("t5_err", err, 1);
        check("t5_cred_hold", credits, 4);
        cycle(1'b1, 17'h0_0101, 1'b0, tk);
        cycle(1'b1, 17'h0_0202, 1'b0, tk);
        cycle(1'b1, 17'h0_0303, 1'b0, tk);
        cycle(1'b1, 17'h0_0404, 1'b0, tk);
        cycle(1'b1, 17'h0_0505, 1'b0, tk);
        cycle(1'b1, 17'h0_0606, 1'b0, tk);
        check("t5_stall", stall, 1);
        check("t5_accept_full", accept, 0);
        check("t5_err_sticky", err, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_credits", credits, 4);
        check("t5_rst_accept", accept, 1);
        check("t5_rst_stall", stall, 0);
        check("t5_rst_err", err, 0);
        check("t5_rst_v", v_out, 0);
        check("t5_rst_d", d_out, 0);
        exp_q.delete();                       // buffered words are discarded
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            cycle(1'b0, '0, 1'b0, tk);
            check("t5_dropped_v", v_out, 0);
        end
        check("t5_after_credits", credits, 4);

        // 6: random stream against a depth-4 downstream model
        ds       = 0;
        accepted = 0;
        cyc      = 0;
        word     = 17'($urandom);
        while ((accepted < 200 || exp_q.size() != 0) && cyc < 5000) begin
            s  = (accepted < 200) && ($urandom_range(0, 3) != 0);
            cr = (ds > 0) && ($urandom_range(0, 2) != 0);
            cycle(s, word, cr, tk);
            if (tk) begin
                accepted++;
                word = 17'($urandom);
            end
            if (cr) ds--;
            if (v_out) ds++;
            check("t6_credit_conservation", 32'(credits), 32'(CREDITS - ds));
            cyc++;
        end
        check("t6_words_accepted", accepted, 200);
        check("t6_all_delivered", exp_q.size(), 0);
        cyc = 0;
        while (ds > 0 && cyc < 100) begin
            cycle(1'b0, '0, 1'b1, tk);
            ds--;
            cyc++;
        end
        check("t6_final_credits", credits, 4);
        check("t6_final_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/credit_tx.md
Name: credit_tx

Overview:
- Transmit end of the DySER credit-based flow-control link: the sender that feeds a downstream flow-control stage or FIFO.
- That downstream stage returns one credit pulse each time it frees a slot.
- credit_tx accepts words from the core side into a 2-entry buffer and forwards them as single-cycle valid pulses while it holds credits.
- It tracks downstream occupancy with a credit counter initialised to the downstream depth. Used at every core-to-fabric input port.

Parameters:
ID, 0, port identifier (debug only)
CREDITS, 4, initial credit count = downstream buffer depth (1..7)
CNT_W, 3, credit counter width; must hold CREDITS

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
d_in  in  `DATA_WIDTH+1  word from core (includes predicate bit)
send  in  1  core strobe; d_in valid this cycle
accept  out  1  block can take a word this cycle; send counts only when accept=1
credit_in  in  1  one-cycle pulse from downstream; returns one slot
d_out  out  `DATA_WIDTH+1  registered word to fabric
v_out  out  1  registered; one pulse per transmitted word
credits  out  CNT_W  current credit count
stall  out  1  buffer non-empty and credits==0
err  out  1  sticky; credit returned while counter already at CREDITS

Behaviour:
- Reset, asynchronous when rst_n=0: v_out=0, d_out=0, credits=CREDITS, buffer empty, accept=1, stall=0, err=0, state=IDLE. Reset mid-operation drops buffered words and restores full credit.
- Buffer: 2 entries, circular, with rd/wr pointers and a 2-bit occupancy count.
  - accept = (occupancy<2). It is a function of registered state only; there is no combinational path from send or credit_in.
  - send & accept: d_in is written at the edge.
  - send & ~accept: ignored; the core must hold the word.
- Transmit, evaluated at each edge:
  - If occupancy>0 and credits>0: d_out<=head word, v_out<=1, pop, and credits decrement.
  - Otherwise v_out<=0 and d_out holds its last value.
- Latency: a word written at edge k reaches v_out no earlier than edge k+1. There is no bypass.
- Simultaneous push and pop at one edge: occupancy is unchanged and both pointers advance. A push while occupancy==2 is impossible because accept=0.
- Credit arithmetic:
  - next = credits - pop + credit_in. Pop and credit_in in the same edge leave credits unchanged.
  - credit_in with credits==CREDITS and no pop: credits hold and err<=1 (sticky until reset).
  - Credits never go below 0, because a pop requires credits>0.
- Pointer wrap: the pointers wrap 1->0.
- FSM, 2-bit state register; the state is updated from the next-cycle occupancy and credits:
  - IDLE (00): occupancy==0.
  - ACTIVE (01): occupancy>0 and credits>0.
  - STALL (10): occupancy>0 and credits==0.
  - Transitions:
    - IDLE->ACTIVE on push while credits>0; IDLE->STALL on push while credits==0.
    - ACTIVE->IDLE when the last word pops with no push.
    - ACTIVE->STALL when the last credit is consumed with a word remaining.
    - STALL->ACTIVE on credit_in.
  - Illegal 11 -> IDLE.
- stall = (state==STALL).
- Output ordering: strictly FIFO; no word is duplicated or lost outside reset.

Decomposition:
- Shared include dyser_config.v: `DATA_WIDTH (existing) and new `CREDIT_WIDTH default 3.
- FSM encodings are local parameters.
- One natural sub-module: credit_cnt. It is a saturating up/down counter with load-on-reset value CREDITS, inc=credit_in, dec=pop, and an overflow flag driving err.

Test Plan:
1. Release reset -> accept=1, credits=4, v_out=0, stall=0, err=0.
2. Send A,B,C,D on 4 consecutive cycles, no credit_in -> v_out pulses A,B,C,D in order starting one edge after A; credits 4->0.
3. Continue from 2: send E and F -> accept drops to 0 and stall=1. Pulse credit_in once -> next edge v_out=1 with d_out=E, credits back to 0, F still held.
4. At credits=2 with buffer non-empty, assert credit_in in the same cycle as a transmit -> credits stays 2, and v_out shows the head word.
5. At credits=4, idle buffer, pulse credit_in -> err=1, credits=4. Then assert rst_n=0 mid-STALL -> all outputs at reset values, buffered words discarded.
6. Randomised send/credit_in stream of 200 words against a scoreboard -> every word appears exactly once in order; credits + in-flight == 4 at every edge.
